rot16_arbiter: RTL and testbench

Two-requester front end for the ALU's shared 16-bit rotate datapath. Arbitrates between two independent valid/ready requesters with round-robin priority, performs the requested rotation, and holds the result in a single registered output stage with valid/ready backpressure. Sits between the ALU issue logic and the writeback mux, so one rotate datapath serves both requesters at up to one rotation per cycle.

---
 rtl/rot16_arbiter_pkg.sv | 22 ++
 rtl/rot16_arbiter_if.sv | 39 +++
 rtl/rot16_core.sv | 31 +++
 rtl/rot16_arbiter.sv | 103 ++++++++++
 tb/tb_rot16_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rot16_arbiter_pkg.sv
// Shared ALU definitions for the 16-bit rotate datapath.
// Holds widths, direction encoding, output-stage states and the request record.
package rot16_arbiter_pkg;

  localparam int ROT_W    = 16;
  localparam int ROT_SH_W = 4;

  localparam logic ROT_LEFT  = 1'b1;
  localparam logic ROT_RIGHT = 1'b0;

  typedef enum logic {
    ROT_EMPTY = 1'b0,
    ROT_FULL  = 1'b1
  } rot_state_e;

  typedef struct packed {
    logic [ROT_W-1:0]    data;
    logic [ROT_SH_W-1:0] shift;
    logic                lr;
  } rot_req_t;

endpackage

// File: rtl/rot16_arbiter_if.sv
// Request/result bundle between two requesters, the arbiter and the writeback consumer.
// The master side (requesters and consumer) drives requests and out_ready.
interface rot16_arbiter_if;
  import rot16_arbiter_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [ROT_W-1:0]    req0_data;
  logic [ROT_SH_W-1:0] req0_shift;
  logic                req0_lr;

  logic                req1_valid;
  logic                req1_ready;
  logic [ROT_W-1:0]    req1_data;
  logic [ROT_SH_W-1:0] req1_shift;
  logic                req1_lr;

  logic                out_valid;
  logic                out_ready;
  logic [ROT_W-1:0]    out_data;
  logic                out_id;

  modport master (
    output req0_valid, req0_data, req0_shift, req0_lr,
    output req1_valid, req1_data, req1_shift, req1_lr,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_shift, req0_lr,
    input  req1_valid, req1_data, req1_shift, req1_lr,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id
  );

endinterface

// File: rtl/rot16_core.sv
// Purely combinational 16-bit rotator built from four log stages (1, 2, 4, 8).
// Every stage feeds the next regardless of direction, so left and right share the chain.
module rot16_core
  import rot16_arbiter_pkg::*;
(
  input  logic [ROT_W-1:0]    data_i,
  input  logic [ROT_SH_W-1:0] shift_i,
  input  logic                lr_i,
  output logic [ROT_W-1:0]    data_o
);

  logic [ROT_W-1:0] stage;

  // NOTE: blocking assignments inside always_comb model a chain of wires; each
  // loop pass reads the previous stage's value and produces the next one.
  always_comb begin
    stage = data_i;
    for (int k = 0; k < ROT_SH_W; k++) begin
      if (shift_i[k]) begin
        if (lr_i == ROT_LEFT) begin
          stage = (stage << (1 << k)) | (stage >> (ROT_W - (1 << k)));
        end else begin
          stage = (stage >> (1 << k)) | (stage << (ROT_W - (1 << k)));
        end
      end
    end
  end

  assign data_o = stage;

endmodule

// File: rtl/rot16_arbiter.sv
// Two-requester round-robin front end for the shared rotate datapath, with a
// single registered result stage under valid/ready backpressure.
module rot16_arbiter
  import rot16_arbiter_pkg::*;
#(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  rot16_arbiter_if.slave   bus
);

  rot_state_e       state_q, state_d;
  logic             prio_q, prio_d;
  logic [ROT_W-1:0] out_data_q, out_data_d;
  logic             out_id_q, out_id_d;

  logic             grant_vld;
  logic             grant_id;
  logic             load_en;
  logic             accept;
  rot_req_t         req0, req1, sel_req;
  logic [ROT_W-1:0] rot_res;

  assign req0 = '{data: bus.req0_data, shift: bus.req0_shift, lr: bus.req0_lr};
  assign req1 = '{data: bus.req1_data, shift: bus.req1_shift, lr: bus.req1_lr};

  // Grant depends only on valids and the pointer, keeping data off the ready path.
  always_comb begin
    grant_vld = bus.req0_valid || bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = prio_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign load_en = (state_q == ROT_EMPTY) || bus.out_ready;
  assign accept  = grant_vld && load_en;

  assign bus.req0_ready = rst_n && accept && !grant_id;
  assign bus.req1_ready = rst_n && accept &&  grant_id;

  assign sel_req = grant_id ? req1 : req0;

  rot16_core u_core (
    .data_i  (sel_req.data),
    .shift_i (sel_req.shift),
    .lr_i    (sel_req.lr),
    .data_o  (rot_res)
  );

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;

    unique case (state_q)
      ROT_EMPTY: begin
        if (accept) state_d = ROT_FULL;
      end
      ROT_FULL: begin
        if (accept) begin
          state_d = ROT_FULL;
        end else if (bus.out_ready) begin
          state_d = ROT_EMPTY;
        end
      end
      default: state_d = ROT_EMPTY;
    endcase

    if (accept) begin
      out_data_d = rot_res;
      out_id_d   = grant_id;
      prio_d     = !grant_id;
    end
  end

  // NOTE: the result register is reset as well as the state, because out_data
  // is visible to the consumer and must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ROT_EMPTY;
      prio_q     <= PRIO_RESET;
      out_data_q <= '0;
      out_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  assign bus.out_valid = (state_q == ROT_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_rot16_arbiter.sv
// Self-checking bench for rot16_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_rot16_arbiter;

  localparam bit PRIO = 1'b0;

  logic clk;
  logic rst_n;

  rot16_arbiter_if bus ();

  rot16_arbiter #(.PRIO_RESET(PRIO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [3:0]  shift;
    bit          lr;
    logic [15:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  bit          r_valid [2];
  logic [15:0] r_data  [2];
  logic [3:0]  r_shift [2];
  bit          r_lr    [2];
  bit          r_oready;

  bit          m_full;
  int          m_prio;
  logic [15:0] m_data;
  int          m_id;
  int          last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rot_ref(input logic [15:0] d, input int s, input bit left);
    int unsigned x;
    int unsigned r;
    x = d;
    if (left) r = (x << s) | (x >> (16 - s));
    else      r = (x >> s) | (x << (16 - s));
    return r[15:0];
  endfunction

  task automatic apply_inputs();
    bus.req0_valid = r_valid[0];
    bus.req0_data  = r_data[0];
    bus.req0_shift = r_shift[0];
    bus.req0_lr    = r_lr[0];
    bus.req1_valid = r_valid[1];
    bus.req1_data  = r_data[1];
    bus.req1_shift = r_shift[1];
    bus.req1_lr    = r_lr[1];
    bus.out_ready  = r_oready;
  endtask

  task automatic model_reset();
    m_full   = 1'b0;
    m_prio   = int'(PRIO);
    m_data   = 16'h0000;
    m_id     = 0;
    last_acc = -1;
  endtask

  task automatic refresh(input int n);
    r_data[n]  = 16'($urandom);
    r_shift[n] = 4'($urandom_range(0, 15));
    r_lr[n]    = 1'($urandom_range(0, 1));
  endtask

  // One clock: drive, check readies against the model, clock, check the result stage.
  task automatic step();
    bit load, gv, acc;
    int g;
    apply_inputs();
    #1;
    load = !m_full || r_oready;
    gv   = r_valid[0] || r_valid[1];
    g    = (r_valid[0] && r_valid[1]) ? m_prio : (r_valid[1] ? 1 : 0);
    acc  = load && gv;
    check("req0_ready", 32'(bus.req0_ready), 32'(acc && g == 0));
    check("req1_ready", 32'(bus.req1_ready), 32'(acc && g == 1));
    @(posedge clk);
    #1;
    if (acc) begin
      m_data   = rot_ref(r_data[g], int'(r_shift[g]), r_lr[g]);
      m_id     = g;
      m_full   = 1'b1;
      m_prio   = 1 - g;
      last_acc = g;
    end else begin
      last_acc = -1;
      if (m_full && r_oready) m_full = 1'b0;
    end
    check("out_valid", 32'(bus.out_valid), 32'(m_full));
    if (m_full) begin
      check("out_data", 32'(bus.out_data), 32'(m_data));
      check("out_id", 32'(bus.out_id), 32'(m_id));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 16'h8001, 4'd1,  1'b1, 16'h0003};
    vecs[1]  = '{1, 16'h1234, 4'd8,  1'b0, 16'h3412};
    vecs[2]  = '{1, 16'h1234, 4'd0,  1'b0, 16'h1234};
    vecs[3]  = '{0, 16'h1234, 4'd0,  1'b1, 16'h1234};
    vecs[4]  = '{0, 16'h0001, 4'd1,  1'b0, 16'h8000};
    vecs[5]  = '{1, 16'h8000, 4'd1,  1'b1, 16'h0001};
    vecs[6]  = '{0, 16'h00FF, 4'd4,  1'b1, 16'h0FF0};
    vecs[7]  = '{1, 16'h00FF, 4'd4,  1'b0, 16'hF00F};
    vecs[8]  = '{0, 16'hABCD, 4'd15, 1'b1, 16'hD5E6};
    vecs[9]  = '{1, 16'h1234, 4'd4,  1'b1, 16'h2341};
    vecs[10] = '{0, 16'h1234, 4'd12, 1'b0, 16'h2341};
    vecs[11] = '{1, 16'hFFFF, 4'd7,  1'b0, 16'hFFFF};

    for (int n = 0; n < 2; n++) begin
      r_valid[n] = 1'b0;
      r_data[n]  = 16'h0000;
      r_shift[n] = 4'd0;
      r_lr[n]    = 1'b0;
    end
    r_oready = 1'b1;

    // Reset state, with a requester already asking.
    rst_n      = 1'b0;
    r_valid[0] = 1'b1;
    r_valid[1] = 1'b1;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    apply_inputs();
    rst_n = 1'b1;
    model_reset();

    // Directed vector table, one requester at a time.
    foreach (vecs[i]) begin
      r_valid[vecs[i].id] = 1'b1;
      r_data[vecs[i].id]  = vecs[i].data;
      r_shift[vecs[i].id] = vecs[i].shift;
      r_lr[vecs[i].id]    = vecs[i].lr;
      step();
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp));
      check($sformatf("vec%0d_id", i), 32'(bus.out_id), 32'(vecs[i].id));
      r_valid[vecs[i].id] = 1'b0;
      step();
    end

    // Contention from reset: grants must alternate starting at PRIO_RESET.
    do_reset();
    refresh(0);
    refresh(1);
    r_valid[0] = 1'b1;
    r_valid[1] = 1'b1;
    r_oready   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("alt_valid", 32'(bus.out_valid), 32'd1);
      check("alt_id", 32'(bus.out_id), 32'(k % 2));
      if (last_acc >= 0) refresh(last_acc);
    end

    // Backpressure: FULL and stalled, both requesters waiting.
    r_oready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_readies", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      check("bp_data", 32'(bus.out_data), 32'(m_data));
      check("bp_id", 32'(bus.out_id), 32'd1);
    end
    r_oready = 1'b1;
    step();
    check("bp_resume_valid", 32'(bus.out_valid), 32'd1);
    check("bp_resume_id", 32'(bus.out_id), 32'd0);
    if (last_acc >= 0) refresh(last_acc);
    step();
    check("bp_next_id", 32'(bus.out_id), 32'd1);

    // Reset while a result is still waiting to be consumed.
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    step();
    step();
    r_valid[0] = 1'b1;
    r_data[0]  = 16'hABCD;
    r_shift[0] = 4'd0;
    r_lr[0]    = 1'b1;
    r_oready   = 1'b0;
    step();
    check("mid_loaded", 32'(bus.out_data), 32'h0000ABCD);
    refresh(0);
    r_valid[1] = 1'b1;
    refresh(1);
    step();
    rst_n = 1'b0;
    apply_inputs();
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("mid_rst_ready1", 32'(bus.req1_ready), 32'd0);
    r_oready = 1'b1;
    apply_inputs();
    @(posedge clk);
    #1;
    check("mid_rst_hold_ready0", 32'(bus.req0_ready), 32'd0);
    check("mid_rst_hold_ready1", 32'(bus.req1_ready), 32'd0);
    rst_n = 1'b1;
    model_reset();
    step();
    check("post_rst_grant", 32'(bus.out_id), 32'(PRIO));
    if (last_acc >= 0) refresh(last_acc);
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    step();
    step();

    // Every shift in both directions on random data.
    for (int lr = 0; lr < 2; lr++) begin
      for (int s = 0; s < 16; s++) begin
        int n;
        n          = s % 2;
        r_valid[n] = 1'b1;
        r_data[n]  = 16'($urandom);
        r_shift[n] = 4'(s);
        r_lr[n]    = 1'(lr);
        step();
        r_valid[n] = 1'b0;
      end
    end
    step();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!r_valid[n] || last_acc == n) begin
          r_valid[n] = ($urandom_range(0, 3) != 0);
          refresh(n);
        end
      end
      r_oready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
